// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole game blocks.
package mole_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    GAP  = 3'd2,
    UP   = 3'd3,
    OVER = 3'd4
  } state_t;

  localparam int         SCORE_W        = 7;
  localparam int         DEF_SCORE_MAX  = 99;
  // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS      = 8'hB8;
  localparam logic [7:0] DEF_LFSR_SEED  = 8'hA5;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; maximal length, never reaches zero from a nonzero seed.
module lfsr8
  import mole_pkg::*;
#(
  parameter logic [7:0] SEED = DEF_LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= SEED;
    else        q <= {q[6:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/mole_game_ctrl.sv
// Round sequencer: gates the countdown timer, schedules moles, judges hits and keeps score.
// state | meaning: IDLE wait start, timer held | ARM clear score, 1 cycle | GAP no mole | UP mole lit | OVER final score shown
module mole_game_ctrl
  import mole_pkg::*;
#(
  parameter int         NUM_HOLES  = 4,
  parameter int         HOLE_W     = 2,
  parameter int         UP_CYCLES  = 50000000,
  parameter int         GAP_CYCLES = 25000000,
  parameter int         SCORE_MAX  = DEF_SCORE_MAX,
  parameter logic [7:0] LFSR_SEED  = DEF_LFSR_SEED
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [NUM_HOLES-1:0] i_hit,
  input  logic                 i_game_over,
  output logic                 o_restart_game,
  output logic [NUM_HOLES-1:0] o_mole,
  output logic [SCORE_W-1:0]   o_score,
  output logic [2:0]           o_state
);

  localparam int CNT_MAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   UP_LAST   = CNT_W'(UP_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [HOLE_W-1:0]   prev_hole;
  logic [7:0]          lfsr_q;
  logic [HOLE_W-1:0]   hole_raw;
  logic [HOLE_W-1:0]   hole_sel;
  logic                hit;
  logic                unused_lfsr;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[7:HOLE_W];

  // Never repeat the previous hole; bump to the next one with natural wrap.
  always_comb begin
    hole_raw = lfsr_q[HOLE_W-1:0];
    hole_sel = (hole_raw == prev_hole) ? hole_raw + 1'b1 : hole_raw;
    hit      = |(i_hit & o_mole);
  end

  assign o_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      o_restart_game <= 1'b1;
      o_mole         <= '0;
      o_score        <= '0;
      cnt            <= '0;
      prev_hole      <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_restart_game <= 1'b1;
          if (i_start) state <= ARM;
        end
        ARM: begin
          o_score        <= '0;
          cnt            <= '0;
          o_restart_game <= 1'b0;
          state          <= GAP;
        end
        GAP: begin
          if (i_game_over) begin
            o_mole <= '0;
            cnt    <= '0;
            state  <= OVER;
          end else if (cnt == GAP_LAST) begin
            o_mole    <= NUM_HOLES'(1) << hole_sel;
            prev_hole <= hole_sel;
            cnt       <= '0;
            state     <= UP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        UP: begin
          // Game over outranks a hit, and a hit outranks the timeout.
          if (i_game_over) begin
            o_mole <= '0;
            cnt    <= '0;
            state  <= OVER;
          end else if (hit) begin
            o_score <= (o_score >= SCORE_TOP) ? SCORE_TOP : o_score + 1'b1;
            o_mole  <= '0;
            cnt     <= '0;
            state   <= GAP;
          end else if (cnt == UP_LAST) begin
            o_mole <= '0;
            cnt    <= '0;
            state  <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OVER: begin
          o_mole <= '0;
          if (i_start) begin
            o_restart_game <= 1'b1;
            state          <= ARM;
          end
        end
        default: begin
          o_restart_game <= 1'b1;
          o_mole         <= '0;
          cnt            <= '0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Self-checking bench for mole_game_ctrl with short timing (UP=10, GAP=5, 4 holes).
module tb_mole_game_ctrl;
  import mole_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic [3:0] i_hit;
  logic       i_game_over;
  logic       o_restart_game;
  logic [3:0] o_mole;
  logic [6:0] o_score;
  logic [2:0] o_state;

  mole_game_ctrl #(
    .NUM_HOLES (4),
    .HOLE_W    (2),
    .UP_CYCLES (10),
    .GAP_CYCLES(5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_hit         (i_hit),
    .i_game_over   (i_game_over),
    .o_restart_game(o_restart_game),
    .o_mole        (o_mole),
    .o_score       (o_score),
    .o_state       (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         start;
    logic [1:0] hmode;   // 0 none, 1 lit hole, 2 unlit holes, 3 all holes
    bit         go;
    state_t     st;
    bit         r;
    logic [1:0] mmode;   // 0 dark, 1 new pick, 2 keep
    logic [6:0] sc;
  } vec_t;

  vec_t        vecs[$];
  logic [14:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          failures = 0;

  logic [7:0]  m_lfsr;
  logic [1:0]  m_prev;
  logic [3:0]  cur_mole;
  int          score_m;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seeded 0xA5, stepping every cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic logic [3:0] pick();
    logic [1:0] h;
    h = m_lfsr[1:0];
    if (h == m_prev) h = h + 2'd1;
    m_prev = h;
    return 4'b0001 << h;
  endfunction

  function automatic logic [3:0] hit_of(input logic [1:0] mode);
    case (mode)
      2'd1:    return cur_mole;
      2'd2:    return ~cur_mole;
      2'd3:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  task automatic compare(input string nm, input logic [14:0] e);
    logic [14:0] got;
    got = {o_state, o_restart_game, o_mole, o_score};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s: got state=%0d restart=%0b mole=%b score=%0d, want state=%0d restart=%0b mole=%b score=%0d",
               nm, got[14:12], got[11], got[10:7], got[6:0], e[14:12], e[11], e[10:7], e[6:0]);
    end
  endtask

  // Called just after a rising edge: drives one cycle, then checks the outputs after the next edge.
  task automatic step(input bit s, input logic [3:0] h, input bit g, input state_t st,
                      input bit r, input logic [3:0] m, input int sc, input string nm);
    i_start = s; i_hit = h; i_game_over = g;
    exp_q.push_back({st, r, m, 7'(sc)});
    name_q.push_back(nm);
    @(posedge clk); #1;
    i_start = 1'b0; i_hit = 4'h0; i_game_over = 1'b0;
    compare(name_q.pop_front(), exp_q.pop_front());
  endtask

  task automatic gap_to_up(input int sc, input string nm);
    for (int k = 0; k < 4; k++) step(0, 4'h0, 0, GAP, 0, 4'h0, sc, nm);
    cur_mole = pick();
    step(0, 4'h0, 0, UP, 0, cur_mole, sc, {nm, "_pick"});
  endtask

  task automatic add(input int n, input bit s, input logic [1:0] hm, input bit g,
                     input state_t st, input bit r, input logic [1:0] mm, input int sc);
    vec_t v;
    v.start = s; v.hmode = hm; v.go = g; v.st = st; v.r = r; v.mmode = mm; v.sc = 7'(sc);
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  initial begin
    rst_n = 1'b1; i_start = 1'b0; i_hit = 4'h0; i_game_over = 1'b0;
    m_prev = 2'd0; cur_mole = 4'h0; score_m = 0;

    // first round: start, 5-cycle gap, unlit hit ignored, lit hit on UP cycle 3,
    // full 10-cycle timeout, then a hit on the timeout cycle itself
    add(1, 1, 0, 0, ARM,  1, 0, 0);
    add(1, 0, 0, 1, GAP,  0, 0, 0);
    add(1, 1, 0, 0, GAP,  0, 0, 0);
    add(1, 0, 3, 0, GAP,  0, 0, 0);
    add(2, 0, 0, 0, GAP,  0, 0, 0);
    add(1, 0, 0, 0, UP,   0, 1, 0);
    add(1, 0, 0, 0, UP,   0, 2, 0);
    add(1, 0, 2, 0, UP,   0, 2, 0);
    add(1, 0, 1, 0, GAP,  0, 0, 1);
    add(4, 0, 0, 0, GAP,  0, 0, 1);
    add(1, 0, 0, 0, UP,   0, 1, 1);
    add(9, 0, 0, 0, UP,   0, 2, 1);
    add(1, 0, 0, 0, GAP,  0, 0, 1);
    add(4, 0, 0, 0, GAP,  0, 0, 1);
    add(1, 0, 0, 0, UP,   0, 1, 1);
    add(8, 0, 0, 0, UP,   0, 2, 1);
    add(1, 1, 2, 0, UP,   0, 2, 1);
    add(1, 0, 1, 0, GAP,  0, 0, 2);

    #1 rst_n = 1'b0;
    #2 compare("reset_hold", {IDLE, 1'b1, 4'h0, 7'd0});
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 50; k++)
      step(0, 4'($urandom_range(0, 15)), (k % 7) == 3, IDLE, 1, 4'h0, 0, "idle");

    foreach (vecs[i]) begin
      logic [3:0] m;
      case (vecs[i].mmode)
        2'd1:    m = pick();
        2'd2:    m = cur_mole;
        default: m = 4'h0;
      endcase
      step(vecs[i].start, hit_of(vecs[i].hmode), vecs[i].go, vecs[i].st, vecs[i].r, m,
           vecs[i].sc, $sformatf("vec%0d", i));
      cur_mole = m;
    end
    score_m = 2;

    // score up to the cap and keep going: must saturate at 99
    for (int rnd = 0; rnd < 100; rnd++) begin
      gap_to_up(score_m, "sat_gap");
      for (int w = $urandom_range(0, 3); w > 0; w--)
        step(0, 4'h0, 0, UP, 0, cur_mole, score_m, "sat_up");
      score_m = (score_m >= 99) ? 99 : score_m + 1;
      step(0, cur_mole, 0, GAP, 0, 4'h0, score_m, (score_m == 99) ? "sat_cap" : "sat_hit");
      cur_mole = 4'h0;
    end

    gap_to_up(99, "go1");
    step(0, cur_mole, 1, OVER, 0, 4'h0, 99, "go_with_hit_cap");
    cur_mole = 4'h0;
    step(0, 4'hF, 1, OVER, 0, 4'h0, 99, "over_hold");
    step(1, 4'h0, 1, ARM,  1, 4'h0, 99, "over_start");
    step(0, 4'h0, 1, GAP,  0, 4'h0, 0,  "arm_ignores_go");
    gap_to_up(0, "go2");
    step(0, cur_mole, 1, OVER, 0, 4'h0, 0, "go_beats_hit");
    cur_mole = 4'h0;
    step(0, 4'hF, 0, OVER, 0, 4'h0, 0, "over_ignores_hit");
    step(1, 4'h0, 0, ARM,  1, 4'h0, 0, "restart_pulse_hi");
    step(0, 4'h0, 0, GAP,  0, 4'h0, 0, "restart_pulse_lo");
    gap_to_up(0, "rst_mid");
    step(0, 4'h0, 0, UP, 0, cur_mole, 0, "rst_mid_up");

    #3 rst_n = 1'b0;
    #1 compare("async_reset", {IDLE, 1'b1, 4'h0, 7'd0});
    m_prev = 2'd0; cur_mole = 4'h0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    step(0, 4'h0, 0, IDLE, 1, 4'h0, 0, "post_rst_idle");
    step(1, 4'h0, 0, ARM,  1, 4'h0, 0, "post_rst_start");
    step(0, 4'h0, 0, GAP,  0, 4'h0, 0, "post_rst_gap");
    gap_to_up(0, "post_rst");
    step(0, cur_mole, 0, GAP, 0, 4'h0, 1, "post_rst_hit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mole_game_ctrl.md
Name: mole_game_ctrl

Overview:
- Top-level game sequencer for the whack-a-mole design.
- Owns the round lifecycle: holds the countdown timer in restart until the player starts a round, then releases it and ends the round when the timer reports game over.
- During play, schedules pseudo-random mole appearances, judges button hits and keeps the score that drives the display logic.

Parameters:
- NUM_HOLES, 4, number of holes/buttons; must be 2, 4 or 8 (power of two).
- HOLE_W, 2, log2(NUM_HOLES); must be kept consistent with NUM_HOLES.
- UP_CYCLES, 50000000, clock cycles a mole stays up (0.5 s at 100 MHz).
- GAP_CYCLES, 25000000, clock cycles with no mole between appearances.
- SCORE_MAX, 99, score saturation value.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  debounced one-cycle start pulse.
- i_hit  input  NUM_HOLES  debounced one-cycle button pulses, one bit per hole.
- i_game_over  input  1  game_over from the countdown timer; level, held high until that timer is restarted.
- o_restart_game  output  1  drives the countdown timer's restart input.
- o_mole  output  NUM_HOLES  one-hot lit mole, or all zero.
- o_score  output  7  current score, 0..SCORE_MAX.
- o_state  output  3  state encoding, for debug/display.

Behaviour:
- Interface: single clock clk; rst_n is asynchronous and active-low. All state is updated on the posedge of clk or cleared immediately on negedge rst_n.
- Reset values:
  - state=IDLE, o_restart_game=1, o_mole=0, o_score=0.
  - cycle counter=0, lfsr=LFSR_SEED, prev_hole=0.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances every cycle in every state, so start timing seeds the sequence. It never reaches zero.
- States (o_state encoding): IDLE=0, ARM=1, GAP=2, UP=3, OVER=4.
- IDLE:
  - o_restart_game=1; the timer holds at 30 and does not count.
  - i_start -> ARM.
- ARM (exactly 1 cycle):
  - o_score<=0; counter<=0; o_restart_game stays 1.
  - Next state: GAP, with o_restart_game=0 from that cycle on.
- GAP:
  - Counter increments each cycle.
  - When counter==GAP_CYCLES-1: select hole h=lfsr[HOLE_W-1:0]. If h==prev_hole, use h+1 (mod NUM_HOLES).
  - On selection: o_mole<=1<<h, prev_hole<=h, counter<=0, -> UP.
- UP:
  - Counter increments each cycle.
  - If (i_hit & o_mole)!=0: o_score<=min(o_score+1, SCORE_MAX), o_mole<=0, counter<=0, -> GAP.
  - Else if counter==UP_CYCLES-1 (timeout): o_mole<=0, counter<=0, -> GAP; score unchanged.
  - Hit on the same cycle as timeout: the hit wins and is scored.
  - Hits on unlit holes are ignored, with no penalty. Multiple i_hit bits including the lit one count as a single hit (+1).
- Game over:
  - i_game_over==1 in GAP or UP -> OVER next cycle, with o_mole<=0.
  - A hit on that same cycle is NOT scored. Game over has priority over hit and timeout.
- OVER:
  - o_restart_game=0; o_score holds its final value; o_mole=0.
  - i_start -> ARM, which pulses restart to the timer and clears the score.
- i_start during ARM, GAP or UP is ignored.
- i_hit in IDLE, ARM or OVER is ignored.
- i_game_over in IDLE, ARM or OVER is ignored; it is stale until restart takes effect.
- Counter width: $clog2(max(UP_CYCLES, GAP_CYCLES)). Counter comparisons are unsigned.
- Latency: hit pulse to o_score/o_mole update = 1 cycle. i_game_over to OVER = 1 cycle.
- Reset asserted mid-game: all outputs return to their reset values immediately and asynchronously; the timer is forced into restart via o_restart_game=1.

Decomposition:
- Shared package mole_pkg holds:
  - state enum (IDLE..OVER, 3 bits);
  - SCORE_W=7, SCORE_MAX=99;
  - LFSR tap mask and default seed.
- One sub-module: lfsr8 (clk, rst_n, seed param, 8-bit q output, free-running), reused by any later randomised blocks.
- Hole selection and scoring stay inline in the FSM.

Test Plan (bench overrides: UP_CYCLES=10, GAP_CYCLES=5, NUM_HOLES=4):
- Reset then idle 50 cycles -> o_restart_game=1, o_mole=0, o_score=0, o_state=0 throughout.
- i_start pulse -> ARM for 1 cycle, then o_restart_game=0. Exactly 5 cycles of GAP, then o_mole one-hot with a hole differing from prev_hole (0 after reset).
- In UP, pulse the i_hit bit matching o_mole on the 3rd cycle -> next cycle o_score=1, o_mole=0, state=GAP. Pulse a non-matching bit -> no change.
- Never hit -> mole drops after exactly 10 cycles, score stays 0. Hit on cycle 10 (the timeout cycle) -> scored, score=1.
- Force o_score to 98, then score 3 hits -> o_score reads 99, 99, 99 (saturates). Assert i_game_over together with a correct hit -> OVER, o_mole=0, hit not scored.
- Deassert rst_n mid-UP (asynchronously, between clock edges) -> outputs return to reset values before the next edge. Afterwards, i_start from OVER -> ARM clears the score to 0 and o_restart_game is high for exactly one cycle.
